// File: rtl/perif_uart_tx_if.sv
// Peripheral-window bus seen by the UART transmitter: write/read strobes,
// address, write data and the read-data path back to the tri-state driver.
interface perif_uart_tx_if;
    logic        perif_select;
    logic        mem_write_en;
    logic        mem_read;
    logic [31:0] address;
    logic [63:0] data_in;
    logic [63:0] data_out;
    logic        data_oe;

    modport master (
        output perif_select, mem_write_en, mem_read, address, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  perif_select, mem_write_en, mem_read, address, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/perif_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by TXDATA stores,
// serialiser FSM on tx, and a pollable STATUS register.
module perif_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clock,
    input  logic            reset,
    perif_uart_tx_if.slave  bus,
    output logic            tx,
    output logic            busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0]      BAUD_TOP = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    typedef struct packed {
        logic [4:0] count;
        logic       overflow;
        logic       tx_active;
        logic       empty;
        logic       full;
    } status_t;

    state_t           state, state_d;
    logic [15:0]      baud_cnt, baud_d;
    logic [2:0]       bit_idx, bit_d;
    logic [7:0]       shift, shift_d;
    logic             tx_d;
    logic             pop;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic             wr_req, accept, rd_status, full, empty, baud_done;
    status_t          status;
    logic             unused_bits;

    assign unused_bits = ^{bus.address[31:4], bus.address[2:0], bus.data_in[63:8]};

    assign wr_req    = bus.perif_select & bus.mem_write_en & ~bus.address[3];
    assign bus.data_oe = bus.perif_select & bus.mem_read & ~bus.mem_write_en;
    assign rd_status = bus.data_oe & bus.address[3];
    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign baud_done = (baud_cnt == '0);
    // a pop in the same edge frees a slot, so a full FIFO can still take the push
    assign accept    = wr_req & (~full | pop);
    assign busy      = ~empty | (state != IDLE);

    always_comb begin
        status           = '0;
        status.count     = 5'(count);
        status.overflow  = overflow;
        status.tx_active = (state != IDLE);
        status.empty     = empty;
        status.full      = full;
        bus.data_out     = rd_status ? 64'(status) : '0;
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    baud_d  = BAUD_TOP;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = BAUD_TOP;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = BAUD_TOP;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_d = STOP;
                    else                 bit_d   = bit_idx + 3'd1;
                end else begin
                    baud_d = baud_cnt - 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = BAUD_TOP;
                    // chain straight into the next start bit when more data waits
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_cnt - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shift_d[0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            shift    <= shift_d;
            tx       <= tx_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            count    <= count + CNT_W'(accept) - CNT_W'(pop);
            // a dropped write wins over a clearing STATUS read in the same edge
            overflow <= (wr_req & ~accept) | (overflow & ~rd_status);
        end
    end

    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= bus.data_in[7:0];
    end

endmodule

// File: tb/tb_perif_uart_tx.sv
// Bench for perif_uart_tx: directed scenarios plus random bus traffic,
// compared every cycle against a frame-timeline reference model.
module tb_perif_uart_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic tx, busy;
    perif_uart_tx_if bus();

    perif_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    int errs   = 0;
    int checks = 0;
    logic [63:0] last_rd;

    // reference model: pending bytes, and the byte currently on the line with
    // the number of cycles elapsed since its frame started
    logic [7:0] q[$];
    logic       m_active;
    int         m_fc;
    logic [7:0] m_cur;
    logic       m_ovf;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 1'b0;
        m_fc     = 0;
        m_cur    = 8'h00;
        m_ovf    = 1'b0;
    endtask

    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_fc / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    function automatic logic [63:0] exp_status();
        logic [63:0] s;
        s = '0;
        s[0]   = (q.size() == D);
        s[1]   = (q.size() == 0);
        s[2]   = m_active;
        s[3]   = m_ovf;
        s[8:4] = 5'(q.size());
        return s;
    endfunction

    task automatic model_step(input logic s, input logic w, input logic r,
                              input logic a3, input logic [7:0] d);
        if (m_active) begin
            m_fc++;
            if (m_fc == 10 * C) begin
                if (q.size() > 0) begin
                    m_cur = q.pop_front();
                    m_fc  = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end else if (q.size() > 0) begin
            m_cur    = q.pop_front();
            m_fc     = 0;
            m_active = 1'b1;
        end
        if (s && w && !a3 && q.size() >= D) m_ovf = 1'b1;
        else if (s && r && !w && a3)        m_ovf = 1'b0;
        if (s && w && !a3 && q.size() < D) q.push_back(d);
    endtask

    task automatic cyc(input logic s, input logic w, input logic r,
                       input logic a3, input logic [7:0] d);
        logic [31:0] a;
        logic        oe;
        @(negedge clock);
        a    = $urandom;
        a[3] = a3;
        bus.perif_select = s;
        bus.mem_write_en = w;
        bus.mem_read     = r;
        bus.address      = a;
        bus.data_in      = {$urandom, $urandom};
        bus.data_in[7:0] = d;
        #1;
        oe = s & r & ~w;
        chk("tx", 64'(tx), 64'(exp_tx()));
        chk("busy", 64'(busy), 64'(m_active || q.size() > 0));
        chk("data_oe", 64'(bus.data_oe), 64'(oe));
        chk("data_out", bus.data_out, (oe && a3) ? exp_status() : 64'h0);
        last_rd = bus.data_out;
        @(posedge clock);
        model_step(s, w, r, a3, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic reset_pulse();
        @(posedge clock);
        #1;
        bus.perif_select = 1'b0;
        bus.mem_write_en = 1'b0;
        bus.mem_read     = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_tx", 64'(tx), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_oe", 64'(bus.data_oe), 64'h0);
        chk("rst_dout", bus.data_out, 64'h0);
        #2 reset = 1'b1;
    endtask

    initial begin
        int r;
        model_reset();
        bus.perif_select = 1'b0;
        bus.mem_write_en = 1'b0;
        bus.mem_read     = 1'b0;
        bus.address      = '0;
        bus.data_in      = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_tx0", 64'(tx), 64'h1);
        chk("rst_busy0", 64'(busy), 64'h0);
        #2 reset = 1'b1;

        idle(2);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("status_after_reset", last_rd, 64'h2);

        // single frame
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        idle(41);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("status_after_55", last_rd, 64'h2);

        // back-to-back frames
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hA1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h02);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("status_b2b", last_rd, 64'h34);
        idle(165);

        // full FIFO: push at the STOP-end pop, then an overflowing write
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hB0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h44);
        idle(36);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("status_ovf_set", last_rd, 64'h4D);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("status_ovf_clr", last_rd, 64'h45);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("read_txdata", last_rd, 64'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        idle(220);

        // reset in the middle of a frame
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        idle(12);
        reset_pulse();
        idle(50);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
            else if (r < 32) cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'($urandom));
            else if (r < 50) cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
            else if (r < 55) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            else if (r < 62) cyc(1'($urandom), 1'($urandom), 1'($urandom),
                                 1'($urandom), 8'($urandom));
            else if (r < 63) idle(200);
            else             idle(1);
        end
        idle(300);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/perif_uart_tx.md
# perif_uart_tx

Memory-mapped UART transmitter on the computer's peripheral window. It is selected by the address decoder's PERIF_select and consumes byte stores that the control unit issues over the shared memory bus. It buffers the bytes in a small FIFO and serialises them 8N1, LSB first, onto a single `tx` line. A status register is readable over the same bus so that polling loops in ROM code can throttle writes.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, default 4: FIFO entries; must be a power of two, 2..16.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it clears all state immediately.
- perif_select  input  1  peripheral window select from the address decoder.
- mem_write_en  input  1  bus write strobe.
- mem_read  input  1  bus read strobe.
- address  input  32  bus address; only bit 3 is decoded. 0 selects TXDATA, 1 selects STATUS.
- data_in  input  64  bus write data; only bits [7:0] are used.
- data_out  output  64  read data. It drives the computer's tri-state mem_data driver.
- data_oe  output  1  read-data enable, equal to perif_select & mem_read & ~mem_write_en.
- tx  output  1  serial line, idle high.
- busy  output  1  high whenever the FIFO is non-empty or a frame is in flight.

## Operation
- Reset values: tx=1, busy=0, data_oe=0, data_out=0, FIFO empty, count=0, overflow=0, FSM=IDLE, baud counter=0, bit index=0.
- Write to TXDATA: a write occurs on a rising edge when perif_select & mem_write_en & address[3]==0.
  - If the FIFO is not full, the write pushes data_in[7:0].
  - If the FIFO is full, the write is dropped and the sticky `overflow` flag is set.
- Writes to STATUS are ignored.
- Read of TXDATA returns 0.
- Read of STATUS returns 64 bits, zero-extended:
  - bit0 full
  - bit1 empty
  - bit2 tx_active (FSM≠IDLE)
  - bit3 overflow
  - bits[8:4] count
- A STATUS read clears `overflow` on the rising edge where data_oe=1 and address[3]=1. If an overflowing write and a clearing read occur in the same edge, overflow ends set.
- data_out is combinational from address and current state. It reads 0 when data_oe=0.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH. A separate count runs 0..FIFO_DEPTH.
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - Simultaneous push and pop: the push is judged against the count after the pop. A push into a full FIFO in the same edge as a pop is therefore accepted, and count is unchanged.
- FSM states and transitions:
  - IDLE: tx=1. If the FIFO is not empty, pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. The register shifts right after each bit. After bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is not empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- The baud counter decrements each cycle. It reloads CLKS_PER_BIT-1 on reaching 0, and that reload is the cycle the state or bit advances.
- tx is a registered output with no combinational glitches.
- reset asserted mid-frame: tx returns to 1 immediately. The FIFO contents are discarded, and no partial frame is resumed after release.

## Timing
- Write-to-tx latency from idle:
  - Push at edge N makes the FIFO non-empty.
  - The FSM pops at edge N+1, and tx falls after edge N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- busy rises after the pushing edge. It falls after the final STOP cycle when the FIFO is empty.
- STATUS bits reflect the registered state after the most recent edge, with zero-cycle read latency.

## Test plan
- Reset, then release with CLKS_PER_BIT=4. Expect tx=1, busy=0, STATUS=0x2. Then assert reset for 3 ns mid-cycle. Expect outputs to return to reset values without waiting for a clock edge.
- Write 0x55 to TXDATA. Expect tx low 1 cycle after the write edge. The 40-cycle sequence is 0,1,0,1,0,1,0,1,0,1, with each level held 4 cycles. Then tx=1, busy=0, STATUS=0x2.
- Write 0xA1, 0x02, 0xFF, 0x80 on consecutive cycles with FIFO_DEPTH=4. STATUS reads tx_active=1 and count=3 (0x34) once the first frame starts. The four frames come out in order with no gap: 160 cycles total.
- Fill the FIFO while a frame is active, then write 0x77. Expect the 0x77 byte to be dropped and STATUS bit3=1. A STATUS read then clears bit3 on the next edge, and 0x77 never appears on tx.
- Write exactly when STOP ends with the FIFO full. Expect the simultaneous pop+push to be accepted, count to stay at 4, and the next frame to start with no gap.
- Read TXDATA and write STATUS (0xFF). Expect data_out=0 and STATUS unchanged. data_oe=0 whenever perif_select=0 or mem_write_en=1.
